// File: rtl/tt_um_load_ctrl.sv
// tt_um_load_ctrl: sequencer for the ternary weight shift-register loader.
// Loads MAX_OUT_LEN rows as two halves each, tracks which row the loader's
// free rotation presents on uo_weights, and runs aligned compute frames.
// Optional build macro: LOAD_CTRL_AUTORUN_EN. When it is defined, a completed
// load goes straight into a compute frame instead of waiting in READY.
//
// state | meaning
// IDLE  | no valid weights (or aborted); waits for load_req
// LOAD  | shifting host data into the loader, two halves per row
// READY | weights loaded; rotation free-running, waits for run_req
// RUN   | one frame, rows 0..MAX_OUT_LEN-1 presented to the MAC

module tt_um_load_ctrl #(
  parameter int MAX_OUT_LEN = 7,
  parameter int RW          = $clog2(MAX_OUT_LEN),
  parameter int CW          = $clog2(2 * MAX_OUT_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_req,
  input  logic          run_req,
  input  logic          abort,
  output logic          ld_ena,
  output logic          ld_half,
  output logic [RW-1:0] row_idx,
  output logic          row_valid,
  output logic          frame_done,
  output logic          weights_ready,
  output logic          busy,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  localparam logic [RW-1:0] LAST_ROW = RW'(MAX_OUT_LEN - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(2 * MAX_OUT_LEN - 1);

`ifdef LOAD_CTRL_AUTORUN_EN
  localparam state_t LOAD_EXIT = S_RUN;
`else
  localparam state_t LOAD_EXIT = S_READY;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   phase_q, phase_d;
  logic            pend_q, pend_d;
  logic            wr_q, wr_d;
  logic            phase_wrap;

  // State register and all sequencing flops; rst beats abort and requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      phase_q <= '0;
      pend_q  <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      wr_q    <= wr_d;
    end
  end

  assign phase_wrap = (phase_q == LAST_ROW);

  // Next-state logic: transitions, load counter, pending run and ready flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    pend_d  = pend_q;
    wr_d    = wr_q;
    if (abort) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
      wr_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (load_req) state_d = S_LOAD;
        end
        S_LOAD: begin
          if (cnt_q == LAST_CNT) begin
            state_d = LOAD_EXIT;
            wr_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_READY: begin
          if (load_req) begin
            state_d = S_LOAD;
            pend_d  = 1'b0;
          end else begin
            if (run_req) pend_d = 1'b1;
            // Frame start is aligned to the rotation wrapping back to row 0.
            if ((pend_q || run_req) && phase_wrap) state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (phase_wrap) begin
            state_d = S_READY;
            pend_d  = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Rotation phase: pinned to row 0 around a load so the loader and the
  // tracker agree on the first post-load row; free-running otherwise.
  always_comb begin
    phase_d = phase_q + 1'b1;
    if (state_q == S_LOAD || state_d == S_LOAD || phase_wrap) phase_d = '0;
  end

  // Output decode, registers only.
  always_comb begin
    ld_ena        = (state_q == S_LOAD);
    ld_half       = (state_q == S_LOAD) && cnt_q[0];
    row_idx       = phase_q;
    row_valid     = (state_q == S_RUN);
    frame_done    = (state_q == S_RUN) && phase_wrap;
    weights_ready = wr_q;
    busy          = (state_q == S_LOAD) || (state_q == S_RUN) || pend_q;
    state         = state_q;
  end

endmodule

// File: tb/tb_tt_um_load_ctrl.sv
// Bench for tt_um_load_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a cycle-count based behavioural model.
module tb_tt_um_load_ctrl;

  localparam int N = 7;
`ifdef LOAD_CTRL_AUTORUN_EN
  localparam bit AUTORUN = 1'b1;
`else
  localparam bit AUTORUN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1, load_req = 1'b0, run_req = 1'b0, abort = 1'b0;
  logic       ld_ena, ld_half, row_valid, frame_done, weights_ready, busy;
  logic [2:0] row_idx;
  logic [1:0] state;

  always #5 clk = ~clk;

  tt_um_load_ctrl dut (
    .clk(clk), .rst(rst), .load_req(load_req), .run_req(run_req), .abort(abort),
    .ld_ena(ld_ena), .ld_half(ld_half), .row_idx(row_idx), .row_valid(row_valid),
    .frame_done(frame_done), .weights_ready(weights_ready), .busy(busy), .state(state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: mode 0 idle, 1 loading, 2 ready, 3 running.
  int m_mode = 0, m_cnt = 0, m_phase = 0;
  bit m_pend = 0, m_wr = 0, m_valid = 0;

  function automatic logic [10:0] model_vec();
    logic [1:0] md;
    logic [2:0] ph;
    md = 2'(m_mode);
    ph = 3'(m_phase);
    return {md, m_mode == 1, (m_mode == 1) && (m_cnt % 2 == 1), ph, m_mode == 3,
            (m_mode == 3) && (m_phase == N - 1), m_wr,
            (m_mode == 1) || (m_mode == 3) || m_pend};
  endfunction

  task automatic check_vec(input string tag);
    logic [10:0] obs, exp;
    obs = {state, ld_ena, ld_half, row_idx, row_valid, frame_done, weights_ready, busy};
    exp = model_vec();
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit l, input bit rq, input bit a);
    int old_mode;
    old_mode = m_mode;
    if (r) begin
      m_mode = 0; m_cnt = 0; m_phase = 0; m_pend = 0; m_wr = 0; m_valid = 1;
      return;
    end
    if (a) begin
      m_mode = 0; m_pend = 0; m_wr = 0; m_cnt = 0;
    end else begin
      case (m_mode)
        0: if (l) begin m_mode = 1; m_cnt = 0; end
        1: begin
          m_cnt++;
          if (m_cnt == 2 * N) begin
            m_mode = AUTORUN ? 3 : 2;
            m_wr   = 1;
            m_cnt  = 0;
          end
        end
        2: begin
          if (l) begin
            m_mode = 1; m_pend = 0; m_cnt = 0;
          end else begin
            if (rq) m_pend = 1;
            if (m_pend && m_phase == N - 1) m_mode = 3;
          end
        end
        default: if (m_phase == N - 1) begin m_mode = 2; m_pend = 0; end
      endcase
    end
    if (old_mode == 1 || m_mode == 1) m_phase = 0;
    else m_phase = (m_phase + 1) % N;
  endtask

  task automatic cyc(input bit r, input bit l, input bit rq, input bit a,
                     input string tag = "cycle");
    rst = r; load_req = l; run_req = rq; abort = a;
    if (m_valid) check_vec(tag);
    @(posedge clk);
    model_step(r, l, rq, a);
    #1;
  endtask

  initial begin
    int nld, nv, first_v, fd_row, fd_at;

    // 1. reset with load_req held
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    check_int("rst_state", int'(state), 0);
    check_bit("rst_ld_ena", ld_ena, 1'b0);
    check_bit("rst_row_valid", row_valid, 1'b0);
    check_bit("rst_weights_ready", weights_ready, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    cyc(0, 0, 0, 0, "idle");

    // 2. full load
    cyc(0, 1, 0, 0, "load_pulse");
    nld = 0;
    for (int g = 0; g < 40 && ld_ena === 1'b1; g++) begin
      check_bit("ld_half_seq", ld_half, 1'(nld % 2));
      nld++;
      cyc(0, 0, 0, 0, "load");
    end
    check_int("load_len", nld, 2 * N);
    check_int("post_load_state", int'(state), AUTORUN ? 3 : 2);
    check_bit("post_load_wr", weights_ready, 1'b1);
    check_int("post_load_row", int'(row_idx), 0);

`ifndef LOAD_CTRL_AUTORUN_EN
    // 3. run_req on the 4th READY cycle (phase 3)
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    check_int("phase_before_run", int'(row_idx), 3);
    cyc(0, 0, 1, 0, "run_req");
    nv = 0; first_v = -1; fd_row = -1;
    for (int i = 0; i < 20; i++) begin
      if (row_valid === 1'b1) begin
        if (first_v < 0) first_v = i;
        check_int("frame_row", int'(row_idx), nv);
        nv++;
        if (frame_done === 1'b1) fd_row = int'(row_idx);
      end
      cyc(0, 0, 0, 0, "frame");
    end
    check_int("frame_start_delay", first_v, 3);
    check_int("frame_rows", nv, N);
    check_int("frame_done_row", fd_row, N - 1);
    check_int("after_frame_state", int'(state), 2);
`else
    // 6. autorun: the frame is already in progress from row 0
    fd_at = -1;
    for (int i = 0; i < 10; i++) begin
      if (frame_done === 1'b1 && fd_at < 0) fd_at = i;
      cyc(0, 0, 0, 0, "autorun_frame");
    end
    check_int("autorun_frame_done_at", fd_at, N - 1);
`endif

    // 4. abort at LOAD cnt=5
    cyc(0, 1, 0, 0, "reload");
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, "load");
    cyc(0, 0, 0, 1, "abort");
    check_int("abort_state", int'(state), 0);
    check_bit("abort_ld_ena", ld_ena, 1'b0);
    check_bit("abort_wr", weights_ready, 1'b0);
    cyc(0, 0, 1, 0, "run_in_idle");
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, "idle");
    check_int("idle_after_run_req", int'(state), 0);
    check_bit("idle_no_valid", row_valid, 1'b0);

    // 5. load_req + run_req together in READY
    cyc(0, 1, 0, 0, "load");
    for (int i = 0; i < 2 * N + N + 1; i++) cyc(0, 0, 0, 0, "to_ready");
    check_int("ready_before_both", int'(state), 2);
    cyc(0, 1, 1, 0, "load_and_run");
    check_int("both_state", int'(state), 1);
    nv = 0;
    for (int i = 0; i < 2 * N + 2 * N; i++) begin
      if (row_valid === 1'b1) nv++;
      cyc(0, 0, 0, 0, "after_both");
    end
    check_int("both_run_rows", nv, AUTORUN ? N : 0);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom % 400) == 0, ($urandom % 25) == 0, ($urandom % 8) == 0,
          ($urandom % 60) == 0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
